// File: rtl/wb_hyperram_arbiter_pkg.sv
// Shared types and bus widths for the Wishbone HyperRAM arbiter.
package wb_hyperram_arbiter_pkg;

   localparam int WB_AW = 32;
   localparam int WB_DW = 32;
   localparam int WB_SW = WB_DW / 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_OWN     = 2'd1,
      ST_RELEASE = 2'd2
   } arb_state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wb_hyperram_arbiter_rr.sv
// Combinational round-robin pick: first requester after last, wrapping.
module wb_hyperram_arbiter_rr
   import wb_hyperram_arbiter_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_i,
   output logic          vld_o,
   output logic [IW-1:0] idx_o
);

   logic [N-1:0] rot;
   logic [IW:0]  off;
   logic [IW:0]  sum;

   always_comb begin
      // rot[j] is the request of master (last+1+j) mod N
      rot   = N'({req_i, req_i} >> ({1'b0, last_i} + (IW+1)'(1)));
      off   = '0;
      vld_o = 1'b0;
      for (int j = N - 1; j >= 0; j--) begin
         if (rot[j]) begin
            off   = (IW+1)'(j);
            vld_o = 1'b1;
         end
      end
      sum = {1'b0, last_i} + (IW+1)'(1) + off;
      if (sum >= (IW+1)'(N)) begin
         sum = sum - (IW+1)'(N);
      end
      idx_o = sum[IW-1:0];
   end

endmodule

// File: rtl/wb_hyperram_arbiter.sv
// Round-robin Wishbone arbiter sharing one HyperRAM slave among masters,
// with a per-grant transfer cap and an ACK watchdog that aborts with ERR.
module wb_hyperram_arbiter
   import wb_hyperram_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int MAX_XFERS   = 4,
   parameter int TIMEOUT     = 1023
) (
   input  logic                         wb_clk_i,
   input  logic                         wb_rstn_i,
   input  logic [NUM_MASTERS-1:0]       m_cyc_i,
   input  logic [NUM_MASTERS-1:0]       m_stb_i,
   input  logic [NUM_MASTERS-1:0]       m_we_i,
   input  logic [WB_SW*NUM_MASTERS-1:0] m_sel_i,
   input  logic [WB_AW*NUM_MASTERS-1:0] m_adr_i,
   input  logic [WB_DW*NUM_MASTERS-1:0] m_dat_i,
   output logic [NUM_MASTERS-1:0]       m_ack_o,
   output logic [NUM_MASTERS-1:0]       m_err_o,
   output logic [WB_DW-1:0]             m_dat_o,
   output logic                         s_cyc_o,
   output logic                         s_stb_o,
   output logic                         s_we_o,
   output logic [WB_SW-1:0]             s_sel_o,
   output logic [WB_AW-1:0]             s_adr_o,
   output logic [WB_DW-1:0]             s_dat_o,
   input  logic                         s_ack_i,
   input  logic [WB_DW-1:0]             s_dat_i
);

   localparam int IW = idx_w(NUM_MASTERS);
   localparam int CW = $clog2(MAX_XFERS + 1);
   localparam int WW = $clog2(TIMEOUT + 1);

   arb_state_e      state_q, state_d;
   logic [IW-1:0]   grant_q, grant_d;
   logic [IW-1:0]   last_q, last_d;
   logic [CW-1:0]   xfer_q, xfer_d;
   logic [WW-1:0]   wdog_q, wdog_d;

   logic            pick_vld;
   logic [IW-1:0]   pick_idx;
   logic            own;
   logic            g_cyc;
   logic            g_stb;
   logic            cap;
   logic            tmo;
   logic            ack;

   logic [WB_SW-1:0] sel_a [NUM_MASTERS];
   logic [WB_AW-1:0] adr_a [NUM_MASTERS];
   logic [WB_DW-1:0] dat_a [NUM_MASTERS];

   for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
      assign sel_a[i] = m_sel_i[WB_SW*i +: WB_SW];
      assign adr_a[i] = m_adr_i[WB_AW*i +: WB_AW];
      assign dat_a[i] = m_dat_i[WB_DW*i +: WB_DW];
   end

   wb_hyperram_arbiter_rr #(
      .N  (NUM_MASTERS),
      .IW (IW)
   ) u_rr (
      .req_i  (m_cyc_i),
      .last_i (last_q),
      .vld_o  (pick_vld),
      .idx_o  (pick_idx)
   );

   assign own   = (state_q == ST_OWN);
   assign g_cyc = m_cyc_i[grant_q];
   assign g_stb = m_stb_i[grant_q];
   assign cap   = (xfer_q >= CW'(MAX_XFERS));
   assign tmo   = (wdog_q == WW'(TIMEOUT));
   assign ack   = s_ack_i & s_stb_o;

   always_comb begin
      s_cyc_o = own & g_cyc;
      s_stb_o = own & g_stb & ~cap & ~tmo;
      s_we_o  = own & m_we_i[grant_q];
      s_sel_o = own ? sel_a[grant_q] : '0;
      s_adr_o = own ? adr_a[grant_q] : '0;
      s_dat_o = own ? dat_a[grant_q] : '0;
      m_dat_o = s_dat_i;
      m_ack_o = '0;
      m_err_o = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         m_ack_o[i] = ack & (grant_q == IW'(i));
         m_err_o[i] = own & tmo & (grant_q == IW'(i));
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      xfer_d  = xfer_q;
      wdog_d  = wdog_q;
      unique case (state_q)
         ST_IDLE: begin
            xfer_d = '0;
            wdog_d = '0;
            if (pick_vld) begin
               grant_d = pick_idx;
               last_d  = pick_idx;
               state_d = ST_OWN;
            end
         end
         ST_OWN: begin
            if (tmo) begin
               state_d = ST_RELEASE;
            end else if (ack) begin
               xfer_d = xfer_q + CW'(1);
               wdog_d = '0;
               if (xfer_d == CW'(MAX_XFERS) || !g_cyc) begin
                  state_d = ST_RELEASE;
               end
            end else begin
               if (s_stb_o) begin
                  wdog_d = wdog_q + WW'(1);
               end
               if (!g_cyc) begin
                  state_d = ST_RELEASE;
               end
            end
         end
         ST_RELEASE: begin
            // one cycle with CYC low closes the HyperRAM chip select
            xfer_d  = '0;
            wdog_d  = '0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         last_q  <= IW'(NUM_MASTERS - 1);
         xfer_q  <= '0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         xfer_q  <= xfer_d;
         wdog_q  <= wdog_d;
      end
   end

endmodule

// File: tb/tb_wb_hyperram_arbiter.sv
// Bench for wb_hyperram_arbiter: two masters, memory slave model with
// random ACK latency, scoreboarded against a round-robin grant model.
module tb_wb_hyperram_arbiter;

   localparam int NM   = 2;
   localparam int MAXX = 4;
   localparam int TMO  = 16;

   logic        clk;
   logic        rst_n;
   logic [1:0]  mcyc, mstb, mwe;
   logic [3:0]  msel [2];
   logic [31:0] madr [2];
   logic [31:0] mdat [2];
   logic [7:0]  m_sel_i;
   logic [63:0] m_adr_i;
   logic [63:0] m_dat_i;
   logic [1:0]  m_ack_o, m_err_o;
   logic [31:0] m_dat_o;
   logic        s_cyc, s_stb, s_we;
   logic [3:0]  s_sel;
   logic [31:0] s_adr, s_wdat;
   logic        s_ack;
   logic [31:0] s_rdat;

   logic        stall;
   int          lat;
   int          wr_cnt;
   logic [31:0] cur;
   logic [31:0] mem [logic [31:0]];
   int          ack_q [$];

   int vec = 0;
   int miss = 0;

   assign m_sel_i = {msel[1], msel[0]};
   assign m_adr_i = {madr[1], madr[0]};
   assign m_dat_i = {mdat[1], mdat[0]};

   wb_hyperram_arbiter #(
      .NUM_MASTERS (NM),
      .MAX_XFERS   (MAXX),
      .TIMEOUT     (TMO)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rstn_i (rst_n),
      .m_cyc_i   (mcyc),
      .m_stb_i   (mstb),
      .m_we_i    (mwe),
      .m_sel_i   (m_sel_i),
      .m_adr_i   (m_adr_i),
      .m_dat_i   (m_dat_i),
      .m_ack_o   (m_ack_o),
      .m_err_o   (m_err_o),
      .m_dat_o   (m_dat_o),
      .s_cyc_o   (s_cyc),
      .s_stb_o   (s_stb),
      .s_we_o    (s_we),
      .s_sel_o   (s_sel),
      .s_adr_o   (s_adr),
      .s_dat_o   (s_wdat),
      .s_ack_i   (s_ack),
      .s_dat_i   (s_rdat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_ack  <= 1'b0;
         s_rdat <= '0;
         lat    <= 0;
      end else if (s_ack) begin
         s_ack <= 1'b0;
      end else if (s_cyc && s_stb && !stall) begin
         if (lat != 0) begin
            lat <= lat - 1;
         end else begin
            s_ack <= 1'b1;
            lat   <= int'($urandom_range(0, 2));
            if (s_we) begin
               cur = mem.exists(s_adr) ? mem[s_adr] : 32'h0;
               for (int b = 0; b < 4; b++)
                  if (s_sel[b]) cur[8*b +: 8] = s_wdat[8*b +: 8];
               mem[s_adr] = cur;
               wr_cnt = wr_cnt + 1;
            end else begin
               s_rdat <= mem.exists(s_adr) ? mem[s_adr] : 32'h0;
            end
         end
      end
   end

   task automatic do_reset();
      mcyc  = '0;
      mstb  = '0;
      stall = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic do_xfer(input int k, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel,
                          input logic we, output logic [31:0] rdat,
                          output logic [1:0] ackv, output int st);
      int n;
      madr[k] = adr;
      mdat[k] = dat;
      msel[k] = sel;
      mwe[k]  = we;
      mstb[k] = 1'b1;
      n = 0;
      st = 2;
      rdat = '0;
      ackv = '0;
      while (n < 300) begin
         @(negedge clk);
         if (m_ack_o[k]) begin
            st = 0;
            rdat = m_dat_o;
            ackv = m_ack_o;
            ack_q.push_back(k);
            break;
         end
         if (m_err_o[k]) begin
            st = 1;
            break;
         end
         n++;
      end
      @(posedge clk);
      #1 mstb[k] = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      mcyc = 2'b11;
      mstb = 2'b11;
      mwe = 2'b00;
      madr[0] = 32'h1000;
      madr[1] = 32'h2000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vec++;
      if (s_cyc !== 1'b0) begin
         miss++;
         $display("FAIL reset_cyc got %b exp 0", s_cyc);
      end
      vec++;
      if (m_ack_o !== 2'b00 || m_err_o !== 2'b00) begin
         miss++;
         $display("FAIL reset_ackerr got %b/%b exp 00/00", m_ack_o, m_err_o);
      end
      vec++;
      if (s_stb !== 1'b0) begin
         miss++;
         $display("FAIL reset_stb got %b exp 0", s_stb);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      vec++;
      if (s_cyc !== 1'b0) begin
         miss++;
         $display("FAIL reset_idle_latency got %b exp 0", s_cyc);
      end
      @(negedge clk);
      vec++;
      if (s_cyc !== 1'b1 || s_adr !== 32'h1000) begin
         miss++;
         $display("FAIL reset_first_grant got cyc=%b adr=%h exp 1/00001000",
                  s_cyc, s_adr);
      end
      do_reset();
   endtask

   task automatic test_round_robin();
      logic [31:0] wd [2][8];
      logic [3:0]  ws [2][8];
      int          exp_q [$];
      int          left [2];
      int          who;
      int          n;
      logic [31:0] ev;
      do_reset();
      mem.delete();
      ack_q.delete();
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 8; i++) begin
            wd[k][i] = $urandom;
            ws[k][i] = 4'($urandom_range(1, 15));
         end
      @(posedge clk);
      #1;
      fork
         begin
            logic [31:0] rd0;
            logic [1:0]  av0;
            int          st0;
            mcyc[0] = 1'b1;
            for (int i = 0; i < 8; i++)
               do_xfer(0, 32'h100 + 32'(4*i), wd[0][i], ws[0][i], 1'b1,
                       rd0, av0, st0);
            mcyc[0] = 1'b0;
         end
         begin
            logic [31:0] rd1;
            logic [1:0]  av1;
            int          st1;
            mcyc[1] = 1'b1;
            for (int i = 0; i < 8; i++)
               do_xfer(1, 32'h200 + 32'(4*i), wd[1][i], ws[1][i], 1'b1,
                       rd1, av1, st1);
            mcyc[1] = 1'b0;
         end
      join
      left[0] = 8;
      left[1] = 8;
      who = 0;
      while (left[0] + left[1] > 0) begin
         if (left[who] == 0) who = 1 - who;
         n = (left[who] < MAXX) ? left[who] : MAXX;
         repeat (n) exp_q.push_back(who);
         left[who] -= n;
         who = 1 - who;
      end
      vec++;
      if (ack_q.size() != exp_q.size()) begin
         miss++;
         $display("FAIL rr_count got %0d exp %0d", ack_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < ack_q.size(); i++) begin
         vec++;
         if (ack_q[i] != exp_q[i]) begin
            miss++;
            $display("FAIL rr_order[%0d] got %0d exp %0d", i, ack_q[i], exp_q[i]);
         end
      end
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 8; i++) begin
            ev = '0;
            for (int b = 0; b < 4; b++)
               if (ws[k][i][b]) ev[8*b +: 8] = wd[k][i][8*b +: 8];
            cur = 32'(32'h100 * (k + 1) + 4*i);
            vec++;
            if (!mem.exists(cur) || mem[cur] !== ev) begin
               miss++;
               $display("FAIL rr_mem[%h] got %h exp %h", cur,
                        mem.exists(cur) ? mem[cur] : 32'hx, ev);
            end
         end
   endtask

   task automatic test_single_read();
      logic [31:0] rd;
      logic [1:0]  av;
      int          st;
      int          n;
      logic [31:0] v44;
      v44 = $urandom;
      mem[32'h40] = 32'hDEADBEEF;
      mem[32'h44] = v44;
      @(posedge clk);
      #1 mcyc[1] = 1'b1;
      do_xfer(1, 32'h40, 32'h0, 4'hF, 1'b0, rd, av, st);
      mcyc[1] = 1'b0;
      vec++;
      if (st != 0 || rd !== 32'hDEADBEEF) begin
         miss++;
         $display("FAIL rd_data st=%0d got %h exp deadbeef", st, rd);
      end
      vec++;
      if (av !== 2'b10) begin
         miss++;
         $display("FAIL rd_ackvec got %b exp 10", av);
      end
      @(negedge clk);
      vec++;
      if (s_cyc !== 1'b0) begin
         miss++;
         $display("FAIL rd_cyc_drop got %b exp 0", s_cyc);
      end
      @(posedge clk);
      #1 mcyc[1] = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s_cyc && n < 20) begin
         n++;
         @(negedge clk);
      end
      vec++;
      if (n != 2) begin
         miss++;
         $display("FAIL rd_regrant_gap got %0d exp 2", n);
      end
      do_xfer(1, 32'h44, 32'h0, 4'hF, 1'b0, rd, av, st);
      mcyc[1] = 1'b0;
      vec++;
      if (st != 0 || rd !== v44) begin
         miss++;
         $display("FAIL rd_second st=%0d got %h exp %h", st, rd, v44);
      end
   endtask

   task automatic test_watchdog();
      logic [31:0] rd1;
      logic [1:0]  av1;
      int          st1;
      int          n;
      do_reset();
      ack_q.delete();
      stall = 1'b1;
      @(posedge clk);
      #1;
      fork
         begin
            mcyc[0] = 1'b1;
            madr[0] = 32'h80;
            mwe[0]  = 1'b1;
            msel[0] = 4'hF;
            mstb[0] = 1'b1;
            n = 0;
            for (int c = 0; c < 100; c++) begin
               @(negedge clk);
               if (m_err_o != 2'b00) break;
               if (s_stb) n++;
            end
            vec++;
            if (n != TMO) begin
               miss++;
               $display("FAIL wd_stall_cycles got %0d exp %0d", n, TMO);
            end
            vec++;
            if (m_err_o !== 2'b01 || s_stb !== 1'b0) begin
               miss++;
               $display("FAIL wd_err got err=%b stb=%b exp 01/0", m_err_o, s_stb);
            end
            @(posedge clk);
            #1;
            mcyc[0] = 1'b0;
            mstb[0] = 1'b0;
            stall   = 1'b0;
            @(negedge clk);
            vec++;
            if (s_cyc !== 1'b0 || m_err_o !== 2'b00) begin
               miss++;
               $display("FAIL wd_release got cyc=%b err=%b exp 0/00", s_cyc, m_err_o);
            end
         end
         begin
            mcyc[1] = 1'b1;
            do_xfer(1, 32'h90, 32'h1234_5678, 4'hF, 1'b1, rd1, av1, st1);
            mcyc[1] = 1'b0;
         end
      join
      vec++;
      if (st1 != 0 || av1 !== 2'b10) begin
         miss++;
         $display("FAIL wd_other_grant st=%0d got %b exp 10", st1, av1);
      end
   endtask

   task automatic test_ack_cyc_drop();
      logic [31:0] d;
      int          seen;
      int          extra;
      do_reset();
      mem.delete();
      wr_cnt = 0;
      d = $urandom;
      @(posedge clk);
      #1;
      mcyc[0] = 1'b1;
      madr[0] = 32'h300;
      mdat[0] = d;
      msel[0] = 4'hF;
      mwe[0]  = 1'b1;
      mstb[0] = 1'b1;
      seen = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (m_ack_o[0]) begin
            seen = 1;
            break;
         end
      end
      mcyc[0] = 1'b0;
      #1;
      vec++;
      if (seen == 0 || m_ack_o !== 2'b01 || s_cyc !== 1'b0) begin
         miss++;
         $display("FAIL drop_ack seen=%0d got ack=%b cyc=%b exp 01/0",
                  seen, m_ack_o, s_cyc);
      end
      @(posedge clk);
      #1 mstb[0] = 1'b0;
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (m_ack_o != 2'b00 || s_cyc) extra++;
      end
      vec++;
      if (extra != 0) begin
         miss++;
         $display("FAIL drop_no_extra got %0d exp 0", extra);
      end
      vec++;
      if (wr_cnt != 1 || !mem.exists(32'h300) || mem[32'h300] !== d) begin
         miss++;
         $display("FAIL drop_mem writes=%0d exp 1 data exp %h", wr_cnt, d);
      end
   endtask

   task automatic test_reset_mid_burst();
      int seen;
      int n;
      do_reset();
      @(posedge clk);
      #1;
      mcyc[0] = 1'b1;
      madr[0] = 32'h500;
      mdat[0] = 32'hA5A5_0000;
      msel[0] = 4'hF;
      mwe[0]  = 1'b1;
      mstb[0] = 1'b1;
      seen = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (m_ack_o[0]) begin
            seen = 1;
            break;
         end
      end
      @(posedge clk);
      #2;
      vec++;
      if (seen == 0 || s_cyc !== 1'b1) begin
         miss++;
         $display("FAIL mid_pre seen=%0d cyc=%b exp 1", seen, s_cyc);
      end
      rst_n = 1'b0;
      mcyc = 2'b11;
      mstb = 2'b11;
      madr[1] = 32'h600;
      #1;
      vec++;
      if (s_cyc !== 1'b0 || s_stb !== 1'b0 || m_ack_o !== 2'b00 ||
          m_err_o !== 2'b00) begin
         miss++;
         $display("FAIL mid_reset_out got cyc=%b stb=%b ack=%b err=%b exp 0",
                  s_cyc, s_stb, m_ack_o, m_err_o);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s_cyc && n < 20) begin
         n++;
         @(negedge clk);
      end
      vec++;
      if (n >= 20 || s_adr !== 32'h500) begin
         miss++;
         $display("FAIL mid_first_grant waited=%0d adr=%h exp 00000500", n, s_adr);
      end
      do_reset();
   endtask

   initial begin
      rst_n  = 1'b0;
      mcyc   = '0;
      mstb   = '0;
      mwe    = '0;
      stall  = 1'b0;
      wr_cnt = 0;
      for (int k = 0; k < 2; k++) begin
         msel[k] = '0;
         madr[k] = '0;
         mdat[k] = '0;
      end
      test_reset();
      test_round_robin();
      test_single_read();
      test_watchdog();
      test_ack_cyc_drop();
      test_reset_mid_burst();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
